pmem_arbiter: RTL and testbench
===============================

PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, giving program memory depth in 32-bit words.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, giving the maximum consecutive loader grants while fetch waits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port fetch_req, input, 1 bit: fetch read request.
REQ-006 SHALL have port fetch_addr, input, 32 bits: fetch byte address.
REQ-007 SHALL have port fetch_gnt, output, 1 bit: fetch request accepted this cycle.
REQ-008 SHALL have port fetch_rvalid, output, 1 bit: fetch_rdata valid.
REQ-009 SHALL have port fetch_rdata, output, 32 bits: registered read data.
REQ-010 SHALL have port ld_valid, input, 1 bit: loader write request.
REQ-011 SHALL have port ld_addr, input, 32 bits: loader byte address.
REQ-012 SHALL have port ld_data, input, 32 bits: loader write word.
REQ-013 SHALL have port ld_ready, output, 1 bit: loader write accepted this cycle.
REQ-014 SHALL have port ld_done, input, 1 bit: loader finished image.
REQ-015 SHALL have port ld_err, output, 1 bit: sticky bad-address flag.
REQ-016 SHALL have port load_count, output, $clog2(DEPTH_WORDS)+1 bits: number of words written.
REQ-017 SHALL have port boot_done, output, 1 bit: arbiter is in RUN.
REQ-018 SHALL have ports mem_byte_address (output, 32), mem_write_enable (output, 1), mem_write_data (output, 32) and mem_read_data (input, 32, combinational read): the memory-side port.

Function
REQ-019 States SHALL be BOOT and RUN; BOOT -> RUN on ld_done=1; RUN has no exit except reset; boot_done=1 iff state is RUN.
REQ-020 In BOOT: fetch_gnt=0; ld_ready=ld_valid.
REQ-021 In RUN, fetch_req only: fetch_gnt=1; ld_valid only: ld_ready=1.
REQ-022 In RUN, both requesting: the loader wins unless the starve counter equals STARVE_LIMIT, in which case fetch wins and the counter clears.
REQ-023 Starve counter: increments each cycle the loader is granted while fetch_req=1; clears when fetch is granted or fetch_req=0.
REQ-024 Fetch grant in cycle N: mem_byte_address=fetch_addr unmodified (halfword-aligned RVC addresses pass through); mem_read_data registered into fetch_rdata; fetch_rvalid=1 in N+1 only.
REQ-025 fetch_rdata SHALL hold its value until the next fetch grant.
REQ-026 Loader transfer occurs when ld_valid&&ld_ready: mem_byte_address=ld_addr, mem_write_data=ld_data, mem_write_enable=1, all in the same cycle.
REQ-027 The loader SHALL hold ld_addr and ld_data stable while ld_valid&&!ld_ready.
REQ-028 Bad address (ld_addr[1:0]!=0 or ld_addr[31:2]>=DEPTH_WORDS): the handshake completes with mem_write_enable=0; ld_err sets and remains set until reset; load_count is unchanged.
REQ-029 load_count increments on each good write and saturates at DEPTH_WORDS.
REQ-030 No grant in a cycle: mem_write_enable=0, mem_byte_address=fetch_addr.
REQ-031 ld_valid and ld_done in the same BOOT cycle: the write completes in that cycle and the state is RUN the next cycle.
REQ-032 ld_done in RUN SHALL be ignored.

Reset
REQ-033 While reset_n=0 on a clock edge: state=BOOT; starve counter=0; fetch_rvalid=0; fetch_rdata=0; ld_err=0; load_count=0.
REQ-034 mem_write_enable, fetch_gnt and ld_ready SHALL be 0 in any cycle with reset_n=0, so a write pending when reset asserts mid-operation is dropped.

Configuration
REQ-035 With PMEM_BOOT_HOLD_EN defined: behaviour is as specified above.
REQ-036 With PMEM_BOOT_HOLD_EN undefined: reset loads state=RUN (boot_done=1 in the first cycle after release); ld_done is ignored; loader writes are arbitrated per REQ-022.

Structure
REQ-037 Package pmem_pkg SHALL hold: pmem_state_e {BOOT, RUN}; PMEM_DEPTH_WORDS=256; PMEM_WADDR_W=8; STARVE_LIMIT default.
REQ-038 Sub-module pmem_starve_counter SHALL implement the saturating starve counter with clear, increment and at_limit.

Verification
REQ-039 Reset, then loader writes 0x00200093 at 0x0 and 0x00000013 at 0x4, then ld_done -> load_count=2, boot_done=1 next cycle, ld_err=0.
REQ-040 RUN, fetch_addr=0x4, fetch_req=1 -> fetch_gnt=1, and fetch_rvalid=1 with fetch_rdata=0x00000013 one cycle later.
REQ-041 RUN, fetch_req and ld_valid held high for 10 cycles -> grant pattern L,L,L,L,F,L,L,L,L,F.
REQ-042 Loader ld_addr=0x402 then 0x400 -> ld_ready=1 both times, mem_write_enable=0 both times, ld_err=1, load_count unchanged.
REQ-043 reset_n=0 during ld_valid at 0x8 -> no write, state BOOT, all counters 0.
REQ-044 Build without PMEM_BOOT_HOLD_EN, fetch_req=1 right after reset -> fetch_gnt=1 in the first cycle after reset release.

Source files
------------

// File: rtl/pmem_pkg.sv
// Shared types and defaults for the program-memory arbiter.
package pmem_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } pmem_state_e;

  localparam int PMEM_DEPTH_WORDS  = 256;
  localparam int PMEM_WADDR_W      = 8;
  localparam int PMEM_STARVE_LIMIT = 4;

  // Counter width able to hold 0..limit; at least one bit.
  function automatic int starve_cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/pmem_starve_counter.sv
// Saturating count of consecutive loader wins while fetch is waiting.
module pmem_starve_counter
  import pmem_pkg::*;
#(
  parameter int LIMIT = PMEM_STARVE_LIMIT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam int W = starve_cnt_w(LIMIT);

  logic [W-1:0] cnt;

  assign at_limit = (cnt == W'(LIMIT));

  // Clear wins over increment; hold at the limit until fetch is served.
  always_ff @(posedge clk) begin
    if (!reset_n)                cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (inc && !at_limit)   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Program-memory port arbiter between instruction fetch (read) and the
// boot loader (write). Build option: PMEM_BOOT_HOLD_EN holds the arbiter
// in BOOT until the loader signals ld_done; without it the arbiter starts
// in RUN straight out of reset.
module pmem_arbiter
  import pmem_pkg::*;
#(
  parameter int DEPTH_WORDS  = PMEM_DEPTH_WORDS,
  parameter int STARVE_LIMIT = PMEM_STARVE_LIMIT
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          fetch_req,
  input  logic [31:0]                   fetch_addr,
  output logic                          fetch_gnt,
  output logic                          fetch_rvalid,
  output logic [31:0]                   fetch_rdata,
  input  logic                          ld_valid,
  input  logic [31:0]                   ld_addr,
  input  logic [31:0]                   ld_data,
  output logic                          ld_ready,
  input  logic                          ld_done,
  output logic                          ld_err,
  output logic [$clog2(DEPTH_WORDS):0]  load_count,
  output logic                          boot_done,
  output logic [31:0]                   mem_byte_address,
  output logic                          mem_write_enable,
  output logic [31:0]                   mem_write_data,
  input  logic [31:0]                   mem_read_data
);

  localparam int CW = $clog2(DEPTH_WORDS) + 1;

`ifdef PMEM_BOOT_HOLD_EN
  localparam pmem_state_e RESET_STATE = BOOT;
`else
  localparam pmem_state_e RESET_STATE = RUN;
  logic unused_ld_done;
  assign unused_ld_done = ld_done;
`endif

  pmem_state_e state, state_nxt;
  logic        at_limit;
  logic        ld_xfer;
  logic        ld_bad;

  assign boot_done = (state == RUN);

  // Misaligned or out-of-range writes still handshake but never reach memory.
  assign ld_xfer          = ld_valid && ld_ready;
  assign ld_bad           = (ld_addr[1:0] != 2'b00) ||
                            ({2'b00, ld_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign mem_write_enable = ld_xfer && !ld_bad;
  assign mem_byte_address = ld_xfer ? ld_addr : fetch_addr;
  assign mem_write_data   = ld_data;

  // State register; RUN is terminal until reset.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= RESET_STATE;
    else          state <= state_nxt;
  end

  // Next state: only a BOOT-hold build ever leaves BOOT, on ld_done.
  always_comb begin
    state_nxt = state;
`ifdef PMEM_BOOT_HOLD_EN
    if (state == BOOT && ld_done) state_nxt = RUN;
`endif
  end

  // Grant selection: loader priority with a fetch anti-starvation override.
  always_comb begin
    fetch_gnt = 1'b0;
    ld_ready  = 1'b0;
    if (reset_n) begin
      if (state == BOOT) begin
        ld_ready = ld_valid;
      end else if (fetch_req && ld_valid) begin
        fetch_gnt = at_limit;
        ld_ready  = !at_limit;
      end else begin
        fetch_gnt = fetch_req;
        ld_ready  = ld_valid;
      end
    end
  end

  pmem_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (fetch_gnt || !fetch_req),
    .inc      (ld_xfer && fetch_req),
    .at_limit (at_limit)
  );

  // Fetch read data is captured on grant and held until the next grant.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_rvalid <= 1'b0;
      fetch_rdata  <= '0;
    end else begin
      fetch_rvalid <= fetch_gnt;
      if (fetch_gnt) fetch_rdata <= mem_read_data;
    end
  end

  // Loader bookkeeping: sticky error flag and saturating good-write count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ld_err     <= 1'b0;
      load_count <= '0;
    end else begin
      if (ld_xfer && ld_bad) ld_err <= 1'b1;
      if (mem_write_enable && load_count != CW'(DEPTH_WORDS))
        load_count <= load_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: loader table, fetch table with a
// read-data scoreboard, starvation pattern, mid-write reset and release.
module tb_pmem_arbiter;

  localparam int DEPTH = 256;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef PMEM_BOOT_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic          clk, reset_n;
  logic          fetch_req, fetch_gnt, fetch_rvalid;
  logic [31:0]   fetch_addr, fetch_rdata;
  logic          ld_valid, ld_ready, ld_done, ld_err;
  logic [31:0]   ld_addr, ld_data;
  logic [CW-1:0] load_count;
  logic          boot_done;
  logic [31:0]   mem_byte_address, mem_write_data, mem_read_data;
  logic          mem_write_enable;

  pmem_arbiter #(.DEPTH_WORDS(DEPTH), .STARVE_LIMIT(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .fetch_req        (fetch_req),
    .fetch_addr       (fetch_addr),
    .fetch_gnt        (fetch_gnt),
    .fetch_rvalid     (fetch_rvalid),
    .fetch_rdata      (fetch_rdata),
    .ld_valid         (ld_valid),
    .ld_addr          (ld_addr),
    .ld_data          (ld_data),
    .ld_ready         (ld_ready),
    .ld_done          (ld_done),
    .ld_err           (ld_err),
    .load_count       (load_count),
    .boot_done        (boot_done),
    .mem_byte_address (mem_byte_address),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  // Memory behind the arbiter and the bench's own model of its contents.
  logic [31:0] mem     [DEPTH];
  logic [31:0] exp_mem [DEPTH];

  assign mem_read_data = mem[mem_byte_address[9:2]];

  always @(posedge clk)
    if (mem_write_enable) mem[mem_byte_address[9:2]] <= mem_write_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: push expected word on grant, pop on rvalid.
  always @(negedge clk) begin
    if (fetch_rvalid) begin
      if (sb_q.size() == 0) chk("rvalid_unexpected", 32'(fetch_rvalid), 32'd0);
      else                  chk("fetch_rdata", fetch_rdata, sb_q.pop_front());
    end
    if (fetch_gnt) sb_q.push_back(exp_mem[fetch_addr[9:2]]);
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        done;
    logic        we;
  } ld_vec_t;

  typedef struct {
    logic [31:0] addr;
  } f_vec_t;

  ld_vec_t lv[6];
  f_vec_t  fv[5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'hDEAD_0000 | 32'(i);
      exp_mem[i] = 32'hDEAD_0000 | 32'(i);
    end
    lv[0] = '{32'h0,   32'h0020_0093, 1'b0, 1'b1};
    lv[1] = '{32'h4,   32'h0000_0013, 1'b0, 1'b1};
    lv[2] = '{32'h8,   32'h1111_1111, 1'b0, 1'b1};
    lv[3] = '{32'hC,   32'h2222_2222, 1'b1, 1'b1};
    lv[4] = '{32'h402, 32'h3333_3333, 1'b0, 1'b0};
    lv[5] = '{32'h400, 32'h4444_4444, 1'b0, 1'b0};
    fv[0] = '{32'h4};
    fv[1] = '{32'h0};
    fv[2] = '{32'h8};
    fv[3] = '{32'h6};
    fv[4] = '{32'hC};

    reset_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_boot_done", 32'(boot_done), 32'(!HOLD));
    chk("rst_load_count", 32'(load_count), 32'd0);
    chk("rst_ld_err", 32'(ld_err), 32'd0);
    chk("rst_rvalid", 32'(fetch_rvalid), 32'd0);
    chk("rst_rdata", fetch_rdata, 32'd0);
    @(posedge clk); #1;

    // Loader image, last good write carries ld_done, then two bad addresses
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1'b1; ld_addr = lv[i].addr; ld_data = lv[i].data; ld_done = lv[i].done;
      if (lv[i].we) exp_mem[lv[i].addr[9:2]] = lv[i].data;
      @(negedge clk);
      chk("ld_ready", 32'(ld_ready), 32'd1);
      chk("ld_we", 32'(mem_write_enable), 32'(lv[i].we));
      chk("ld_maddr", mem_byte_address, lv[i].addr);
      chk("ld_boot_done", 32'(boot_done), 32'(!HOLD || i > 3));
      chk("ld_err_prog", 32'(ld_err), 32'(i >= 5));
      chk("ld_count_prog", 32'(load_count), 32'((i < 4) ? i : 4));
      if (lv[i].we) chk("ld_wdata", mem_write_data, lv[i].data);
      @(posedge clk); #1;
    end
    ld_valid = 1'b0; ld_done = 1'b0;
    @(negedge clk);
    chk("ld_count_final", 32'(load_count), 32'd4);
    chk("ld_err_final", 32'(ld_err), 32'd1);
    chk("boot_done_run", 32'(boot_done), 32'd1);
    @(posedge clk); #1;

    // Back-to-back fetches; read data checked by the scoreboard
    for (int i = 0; i < 5; i++) begin
      fetch_req = 1'b1; fetch_addr = fv[i].addr;
      @(negedge clk);
      chk("f_gnt", 32'(fetch_gnt), 32'd1);
      chk("f_ld_ready", 32'(ld_ready), 32'd0);
      chk("f_maddr", mem_byte_address, fv[i].addr);
      chk("f_we", 32'(mem_write_enable), 32'd0);
      @(posedge clk); #1;
    end
    fetch_req = 1'b0;
    @(negedge clk);
    chk("f_last_rvalid", 32'(fetch_rvalid), 32'd1);
    chk("idle_maddr", mem_byte_address, 32'hC);
    @(posedge clk); #1;
    @(negedge clk);
    chk("f_rvalid_drop", 32'(fetch_rvalid), 32'd0);
    chk("f_rdata_hold", fetch_rdata, 32'h2222_2222);
    @(posedge clk); #1;

    // Contention: loader wins four times, then fetch once
    fetch_req = 1'b1; fetch_addr = 32'h0;
    ld_valid = 1'b1; ld_addr = 32'h40; ld_data = 32'h5555_5555;
    exp_mem[16] = 32'h5555_5555;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("starve_fgnt", 32'(fetch_gnt), 32'(k % 5 == 4));
      chk("starve_ldrdy", 32'(ld_ready), 32'(k % 5 != 4));
      @(posedge clk); #1;
    end
    fetch_req = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    chk("starve_count", 32'(load_count), 32'd12);
    @(posedge clk); #1;
    @(negedge clk);
    chk("sb_empty_1", 32'(sb_q.size()), 32'd0);
    @(posedge clk); #1;

    // Reset asserted with a write pending: nothing reaches memory
    reset_n = 1'b0; ld_valid = 1'b1; ld_addr = 32'h8; ld_data = 32'hBAD0_BAD0; fetch_req = 1'b1;
    @(negedge clk);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_we", 32'(mem_write_enable), 32'd0);
    chk("rst_fgnt", 32'(fetch_gnt), 32'd0);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    @(negedge clk);
    chk("rst2_count", 32'(load_count), 32'd0);
    chk("rst2_err", 32'(ld_err), 32'd0);
    chk("rst2_rvalid", 32'(fetch_rvalid), 32'd0);
    chk("rst2_rdata", fetch_rdata, 32'd0);
    chk("rst2_boot_done", 32'(boot_done), 32'(!HOLD));
    chk("rst2_mem8", mem[2], exp_mem[2]);

    // Release with fetch already requesting
    @(posedge clk); #1;
    reset_n = 1'b1; fetch_addr = 32'h0;
    @(negedge clk);
    chk("rel_fgnt", 32'(fetch_gnt), 32'(!HOLD));
    @(posedge clk); #1;
    fetch_req = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("sb_empty_2", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
